t_down_counter_mod: RTL and testbench
=====================================

Name: t_down_counter_mod

Overview:
- Synchronous modulo-N down counter: the counting-down counterpart of the team's mod-13 T-flip-flop up counter.
- Counts from MODULUS-1 down to 0, then wraps back to MODULUS-1.
- Exposes the per-bit toggle mask, so the chain can be checked against discrete T-cell builds.
- Provides a combinational terminal-count (borrow) output for cascading stages and a registered wrap pulse for downstream logic.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 13, count modulus. Legal range is 2 ≤ MODULUS ≤ 2^WIDTH. Any other value is a compile-time error raised by a generate-time check.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; decrement on the clock edge while high.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  registered count.
- t_vec  output  WIDTH  combinational toggle mask: q XOR next-state q.
- tc  output  1  combinational terminal count / borrow for cascading.
- wrap  output  1  registered one-cycle pulse, asserted the cycle after a wrap.
- load_clamp  output  1  registered one-cycle pulse, asserted the cycle after an out-of-range load was clamped.

Behaviour:
- Single clock domain. All state updates on the rising edge of clk. Reset is synchronous and active-high.
- Reset values: q = MODULUS-1, wrap = 0, load_clamp = 0.
- Priority at each edge: rst > load > en > hold.
- Load (load = 1):
  - If load_val < MODULUS: q <= load_val and load_clamp <= 0.
  - Otherwise: q <= MODULUS-1 and load_clamp <= 1.
  - wrap <= 0. en is ignored in that cycle.
- Count (en = 1, load = 0):
  - If q ≠ 0: q <= q-1 and wrap <= 0.
  - If q = 0: q <= MODULUS-1 and wrap <= 1.
  - load_clamp <= 0.
- Hold (en = 0, load = 0): q is unchanged; wrap <= 0 and load_clamp <= 0.
- tc = en & ~load & ~rst & (q == 0). Purely combinational, valid in the same cycle. It feeds the next stage's en, in the same way the up counter's SA/SB/SC toggle chain does.
- t_vec = q ^ q_next, where q_next is the value q takes at the next edge under the priority above. It is all zeros while holding.
- Bit toggling across the wrap boundary is not a plain binary borrow, e.g. for MODULUS = 13, 0 → 12 gives t_vec = 4'b1100.
- Latency:
  - q updates one edge after the request.
  - wrap and load_clamp are asserted exactly one cycle after the triggering edge and last one cycle.
- Reset mid-count: the count is abandoned, q = MODULUS-1 on the next edge, and pending pulses are cleared.
- Simultaneous load and en at q = 0: load wins, no wrap pulse.
- With continuous en, wrap pulses once every MODULUS cycles.
- q never holds a value ≥ MODULUS.

Optional Feature:
- Macro: T_DOWN_COUNTER_DIR_EN.
- Defined:
  - Adds input port "up" (1 bit).
  - When up = 1 the counter increments: q = MODULUS-1 wraps to 0 and pulses wrap.
  - tc becomes en & ~load & ~rst & (q == MODULUS-1).
  - When up = 0 the counter behaves exactly as described above.
  - The direction is sampled on each edge, so it may change every cycle without glitching q.
- Not defined: no "up" port; down-count only.

Test Plan (WIDTH = 4, MODULUS = 13):
- Reset then en = 1 for 14 cycles:
  - q sequence is 12, 11, …, 0, 12.
  - wrap is high only in the cycle after q leaves 0.
  - tc is high only while q = 0.
- load = 1 with load_val = 5, then en = 1 for 2 cycles → q = 5, 4, 3; load_clamp = 0.
- load = 1 with load_val = 14 → q = 12 and load_clamp pulses for 1 cycle. Repeat with load_val = 13 → same result.
- q = 0 with en = 1 and load = 1, load_val = 7 → q = 7, wrap stays 0, tc = 0 during that cycle.
- Mid-count rst (q = 6, en = 1):
  - Next edge: q = 12, wrap = 0.
  - t_vec at q = 0 with en = 1 equals 4'b1100.
- With T_DOWN_COUNTER_DIR_EN, en = 1, up = 1, starting from q = 11:
  - q sequence is 12, 0, 1; wrap pulses once.
  - Toggling up to 0 at q = 1 → q = 0 on the next edge.

Source files
------------

// File: rtl/t_down_counter_mod.sv
`default_nettype none
// ============================================================================
// Module      : t_down_counter_mod
// Description : Synchronous modulo-MODULUS down counter with a toggle-mask
//               output, a combinational terminal count (borrow) for cascading,
//               and registered wrap / load-clamp pulses.
//               Optional macro T_DOWN_COUNTER_DIR_EN adds an "up" direction
//               input; when up = 1 the counter increments instead.
// Revision    : 1.0 - initial release
// ============================================================================
module t_down_counter_mod #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef T_DOWN_COUNTER_DIR_EN
  input  logic             up,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc,
  output logic             wrap,
  output logic             load_clamp
);

  // Reject moduli that cannot be represented or that make no sense.
  generate
    if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
      $error("t_down_counter_mod: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             clamp_q, clamp_d;
  logic             dir_up;
  logic             load_in_range;
  logic [WIDTH-1:0] tc_val;

`ifdef T_DOWN_COUNTER_DIR_EN
  assign dir_up = up;
`else
  assign dir_up = 1'b0;
`endif

  // Extend by one bit so MODULUS = 2**WIDTH compares correctly.
  assign load_in_range = ({1'b0, load_val} < MOD_EXT);

  // Terminal value depends on the counting direction.
  assign tc_val = dir_up ? MAX_VAL : '0;

  // Next-state and pulse computation, priority rst > load > en > hold.
  always_comb begin
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    clamp_d = 1'b0;
    if (rst) begin
      cnt_d = MAX_VAL;
    end else if (load) begin
      if (load_in_range) begin
        cnt_d = load_val;
      end else begin
        cnt_d   = MAX_VAL;
        clamp_d = 1'b1;
      end
    end else if (en) begin
      if (dir_up) begin
        if (cnt_q == MAX_VAL) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d  = MAX_VAL;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= MAX_VAL;
      wrap_q  <= 1'b0;
      clamp_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      clamp_q <= clamp_d;
    end
  end

  assign q          = cnt_q;
  // Toggle mask reflects exactly the bits that will flip at the next edge.
  assign t_vec      = cnt_q ^ cnt_d;
  assign tc         = en & ~load & ~rst & (cnt_q == tc_val);
  assign wrap       = wrap_q;
  assign load_clamp = clamp_q;

endmodule
`default_nettype wire

// File: tb/tb_t_down_counter_mod.sv
`default_nettype none
// ============================================================================
// Module      : tb_t_down_counter_mod
// Description : Scoreboard bench for t_down_counter_mod (WIDTH=4, MODULUS=13).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_t_down_counter_mod;

  localparam int WIDTH = 4;
  localparam int MOD   = 13;
`ifdef T_DOWN_COUNTER_DIR_EN
  localparam bit DIR = 1'b1;
`else
  localparam bit DIR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             load = 1'b0;
  logic             up = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] q, t_vec;
  logic             tc, wrap, load_clamp;

  t_down_counter_mod #(.WIDTH(WIDTH), .MODULUS(MOD)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
`ifdef T_DOWN_COUNTER_DIR_EN
    .up         (up),
`endif
    .q          (q),
    .t_vec      (t_vec),
    .tc         (tc),
    .wrap       (wrap),
    .load_clamp (load_clamp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int tv;
    bit tc;
    bit wr;
    bit cl;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: value of q, wrap, load_clamp in the current cycle.
  int m_q = MOD - 1;
  bit m_w = 1'b0;
  bit m_c = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle of stimulus; expectations for this cycle go to the scoreboard.
  task automatic step(input bit r, input bit e, input bit l, input int lv,
                      input bit u, input bit chk);
    int   nq;
    bit   nw, nc, eu;
    exp_t x;
    @(negedge clk);
    rst      = r;
    en       = e;
    load     = l;
    load_val = lv[WIDTH-1:0];
    up       = u;
    eu       = DIR && u;
    nw = 1'b0;
    nc = 1'b0;
    if (r) begin
      nq = MOD - 1;
    end else if (l) begin
      if (lv < MOD) nq = lv;
      else begin
        nq = MOD - 1;
        nc = 1'b1;
      end
    end else if (e) begin
      if (eu) begin
        nq = (m_q + 1) % MOD;
        nw = (m_q == MOD - 1);
      end else begin
        nq = (m_q + MOD - 1) % MOD;
        nw = (m_q == 0);
      end
    end else begin
      nq = m_q;
    end
    if (chk) begin
      x.q  = m_q;
      x.tv = m_q ^ nq;
      x.tc = e && !l && !r && (m_q == (eu ? MOD - 1 : 0));
      x.wr = m_w;
      x.cl = m_c;
      sb.push_back(x);
    end
    m_q = nq;
    m_w = nw;
    m_c = nc;
  endtask

  // Monitor: samples mid-low-phase, after inputs have settled.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("q",          int'(q),          x.q);
        check("t_vec",      int'(t_vec),      x.tv);
        check("tc",         int'(tc),         int'(x.tc));
        check("wrap",       int'(wrap),       int'(x.wr));
        check("load_clamp", int'(load_clamp), int'(x.cl));
      end
    end
  end

  initial begin
    // Reset, then a full count cycle through the wrap.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) step(0, 1, 0, 0, 0, 1);
    // In-range load then count.
    step(0, 0, 1, 5, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // Out-of-range loads clamp to MODULUS-1.
    step(0, 0, 1, 14, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 13, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // Load beats en at q = 0.
    step(0, 0, 1, 0, 0, 1);
    step(0, 1, 1, 7, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    // Reset mid-count with en high at q = 6.
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    if (DIR) begin
      step(0, 0, 1, 11, 0, 1);
      step(0, 1, 0, 0, 1, 1);
      step(0, 1, 0, 0, 1, 1);
      step(0, 1, 0, 0, 1, 1);
      step(0, 1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
    end
    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 75,
           $urandom_range(0, 99) < 12,
           int'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1,
           1);
    end
    step(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    #4;
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
